// File: rtl/system_top.sv
// system_top: differential board clock in, single core clock out; a UART 8N1
// command interpreter that drives 10 LEDs and a trigger and answers every
// accepted command or argument byte with one status byte.
// Ports: sys_clk_clk_p/_n differential clock, sys_reset async active-high,
//        uart_rxd/uart_txd serial lines (idle high), gpio_led_tri_o[9:0] LEDs,
//        gpio_trig_tri_o[0:0] trigger.
module system_top #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       sys_clk_clk_p,
  input  logic       sys_clk_clk_n,
  input  logic       sys_reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [9:0] gpio_led_tri_o,
  output logic [0:0] gpio_trig_tri_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // The differential buffer reduces to the positive leg; the negative leg
  // only matters to the pad buffer on silicon.
  logic core_clk;
  logic unused_clk_n;
  assign core_clk     = sys_clk_clk_p;
  assign unused_clk_n = sys_clk_clk_n;

  // Reset asserts immediately, releases two core clocks after deassertion.
  logic [1:0] rst_sync_q;
  logic       rst;
  always_ff @(posedge core_clk or posedge sys_reset) begin
    if (sys_reset) rst_sync_q <= 2'b11;
    else           rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst = rst_sync_q[1];

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t      rx_state_q;
  logic           rxd_s1_q, rxd_s2_q, rxd_prev_q;
  logic [CW-1:0]  rx_cnt_q;
  logic [2:0]     rx_bit_q;
  logic [7:0]     rx_sh_q;
  logic [7:0]     rx_byte_q;
  logic           rx_vld_q;
  logic           rx_ferr_q;

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      rx_vld_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rxd_s1_q   <= uart_rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
      rx_vld_q   <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          // Only a high-to-low transition starts a frame, so a line found low
          // after reset is not mistaken for a start bit twice.
          if (rxd_prev_q && !rxd_s2_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rxd_s2_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rxd_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin // RX_STOP
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            if (rxd_s2_q) begin
              rx_vld_q  <= 1'b1;
              rx_byte_q <= rx_sh_q;
            end else begin
              rx_ferr_q <= 1'b1;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- parser ----------------
  typedef enum logic [1:0] {P_CMD, P_ARG_L, P_ARG_H} p_state_t;
  p_state_t   p_state_q;
  logic [9:0] led_q;
  logic       trig_q;
  logic       rep_vld;
  logic [7:0] rep_dat;

  always_comb begin
    rep_vld = 1'b0;
    rep_dat = 8'h3F;
    if (rx_vld_q) begin
      rep_vld = 1'b1;
      if (p_state_q == P_CMD) begin
        case (rx_byte_q)
          8'h4C, 8'h48: rep_vld = 1'b0;  // reply comes with the argument
          8'h54:        rep_dat = 8'h4B;
          8'h72:        rep_dat = led_q[7:0];
          8'h68:        rep_dat = {6'b0, led_q[9:8]};
          default:      rep_dat = 8'h3F;
        endcase
      end else begin
        rep_dat = 8'h4B;
      end
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      p_state_q <= P_CMD;
      led_q     <= '0;
      trig_q    <= 1'b0;
    end else if (rx_ferr_q) begin
      p_state_q <= P_CMD;
    end else if (rx_vld_q) begin
      case (p_state_q)
        P_CMD: begin
          case (rx_byte_q)
            8'h4C:   p_state_q <= P_ARG_L;
            8'h48:   p_state_q <= P_ARG_H;
            8'h54:   trig_q    <= ~trig_q;
            default: p_state_q <= P_CMD;
          endcase
        end
        P_ARG_L: begin
          led_q[7:0] <= rx_byte_q;
          p_state_q  <= P_CMD;
        end
        default: begin
          led_q[9:8] <= rx_byte_q[1:0];
          p_state_q  <= P_CMD;
        end
      endcase
    end
  end

  // ---------------- holding register + transmitter ----------------
  logic       hold_vld_q;
  logic [7:0] hold_q;
  logic       tx_busy_q;
  logic       tx_load;
  logic [8:0] tx_sh_q;
  logic [3:0] tx_bits_q;
  logic [CW-1:0] tx_cnt_q;
  logic       txd_q;

  assign tx_load = !tx_busy_q && hold_vld_q;

  // A slot being drained this cycle counts as free, so a reply that lands on
  // the load cycle is kept rather than dropped.
  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else if (rep_vld && (!hold_vld_q || tx_load)) begin
      hold_vld_q <= 1'b1;
      hold_q     <= rep_dat;
    end else if (tx_load) begin
      hold_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge core_clk or posedge rst) begin
    if (rst) begin
      txd_q     <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= '0;
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
    end else if (tx_load) begin
      txd_q     <= 1'b0;                // start bit
      tx_sh_q   <= {1'b1, hold_q};      // data LSB first, then stop
      tx_bits_q <= '0;
      tx_cnt_q  <= '0;
      tx_busy_q <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_q <= '0;
        if (tx_bits_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          txd_q     <= 1'b1;
        end else begin
          txd_q     <= tx_sh_q[0];
          tx_sh_q   <= {1'b1, tx_sh_q[8:1]};
          tx_bits_q <= tx_bits_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

  assign uart_txd           = txd_q;
  assign gpio_led_tri_o     = led_q;
  assign gpio_trig_tri_o[0] = trig_q;

endmodule

// File: tb/tb_system_top.sv
module tb_system_top;

  logic       clk_p;
  logic       clk_n;
  logic       sys_reset;
  logic       uart_rxd;
  logic       uart_txd;
  logic [9:0] led;
  logic [0:0] trig;

  int checks = 0;
  int fails  = 0;

  logic [8:0] rxq[$];   // {frame_error, byte} of each decoded reply
  bit         mon_en = 0;

  system_top #(.CLKS_PER_BIT(16)) dut (
    .sys_clk_clk_p   (clk_p),
    .sys_clk_clk_n   (clk_n),
    .sys_reset       (sys_reset),
    .uart_rxd        (uart_rxd),
    .uart_txd        (uart_txd),
    .gpio_led_tri_o  (led),
    .gpio_trig_tri_o (trig)
  );

  assign clk_n = ~clk_p;
  initial clk_p = 1'b0;
  always #10 clk_p = ~clk_p;

  // Reply decoder: samples mid-bit on falling edges.
  initial begin : monitor
    logic [7:0] b;
    logic       ok;
    b  = '0;
    ok = 1'b0;
    forever begin
      @(negedge clk_p);
      if (mon_en && uart_txd === 1'b0) begin
        repeat (8) @(negedge clk_p);
        ok = (uart_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk_p);
          b[i] = uart_txd;
        end
        repeat (16) @(negedge clk_p);
        ok = ok && (uart_txd === 1'b1);
        rxq.push_back({~ok, b});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxd = 1'b0;
    repeat (16) @(negedge clk_p);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (16) @(negedge clk_p);
    end
    uart_rxd = stop;
    repeat (16) @(negedge clk_p);
    uart_rxd = 1'b1;
  endtask

  task automatic wait_reply(output logic [8:0] v, output bit got);
    int n;
    n = 0;
    while (rxq.size() == 0 && n < 800) begin
      @(negedge clk_p);
      n++;
    end
    got = (rxq.size() != 0);
    v   = got ? rxq.pop_front() : 9'h1FF;
  endtask

  task automatic test_reset;
    sys_reset = 1'b0;
    uart_rxd  = 1'b1;
    #40 sys_reset = 1'b1;
    #15;
    checks++; if (led !== 10'h000) begin fails++; $display("FAIL reset_led: got %h expected 000", led); end
    checks++; if (trig !== 1'b0) begin fails++; $display("FAIL reset_trig: got %b expected 0", trig); end
    checks++; if (uart_txd !== 1'b1) begin fails++; $display("FAIL reset_txd: got %b expected 1", uart_txd); end
    #25 sys_reset = 1'b0;
    repeat (5) @(negedge clk_p);
    mon_en = 1;
  endtask

  task automatic test_l_cmd;
    logic [8:0] v;
    bit got;
    send_byte(8'h4C, 1'b1);
    fork
      send_byte(8'hA5, 1'b1);
      begin
        repeat (155) @(negedge clk_p);
        checks++; if (led !== 10'h000) begin fails++; $display("FAIL l_led_before: got %h expected 000", led); end
        @(negedge clk_p);
        checks++; if (led !== 10'h0A5) begin fails++; $display("FAIL l_led_after: got %h expected 0a5", led); end
      end
    join
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL l_reply: got %h (seen %0d) expected 04b", v, got); end
    send_byte(8'h72, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h0A5) begin fails++; $display("FAIL r_reply: got %h (seen %0d) expected 0a5", v, got); end
  endtask

  task automatic test_h_cmd;
    logic [8:0] v;
    bit got;
    send_byte(8'h48, 1'b1);
    send_byte(8'hFF, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL h_reply: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (led !== 10'h3A5) begin fails++; $display("FAIL h_led: got %h expected 3a5", led); end
    send_byte(8'h68, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h003) begin fails++; $display("FAIL hq_reply: got %h (seen %0d) expected 003", v, got); end
  endtask

  task automatic test_t_cmd;
    logic [8:0] v;
    bit got;
    send_byte(8'h54, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL t1_reply: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (trig !== 1'b1) begin fails++; $display("FAIL t1_trig: got %b expected 1", trig); end
    send_byte(8'h54, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL t2_reply: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (trig !== 1'b0) begin fails++; $display("FAIL t2_trig: got %b expected 0", trig); end
    send_byte(8'h00, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h03F) begin fails++; $display("FAIL unk_reply: got %h (seen %0d) expected 03f", v, got); end
    send_byte(8'h4C, 1'b1);
    send_byte(8'h54, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL larg_reply: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (led !== 10'h354) begin fails++; $display("FAIL larg_led: got %h expected 354", led); end
    checks++; if (trig !== 1'b0) begin fails++; $display("FAIL larg_trig: got %b expected 0", trig); end
  endtask

  task automatic test_robust;
    logic [8:0] v;
    bit got;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk_p);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk_p);
    checks++; if (rxq.size() != 0) begin fails++; $display("FAIL glitch_reply: got %0d replies expected 0", rxq.size()); end
    send_byte(8'h4C, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (300) @(negedge clk_p);
    checks++; if (rxq.size() != 0) begin fails++; $display("FAIL ferr_reply: got %0d replies expected 0", rxq.size()); end
    checks++; if (led !== 10'h354) begin fails++; $display("FAIL ferr_led: got %h expected 354", led); end
    send_byte(8'h54, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL ferr_t_reply: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (trig !== 1'b1) begin fails++; $display("FAIL ferr_t_trig: got %b expected 1", trig); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] v;
    bit got;
    send_byte(8'h72, 1'b1);
    send_byte(8'h68, 1'b1);
    send_byte(8'h54, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h054) begin fails++; $display("FAIL b2b_r: got %h (seen %0d) expected 054", v, got); end
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h003) begin fails++; $display("FAIL b2b_h: got %h (seen %0d) expected 003", v, got); end
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL b2b_t: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (trig !== 1'b0) begin fails++; $display("FAIL b2b_trig: got %b expected 0", trig); end
  endtask

  task automatic test_reset_mid_reply;
    logic [8:0] v;
    bit got;
    bit saw_low;
    int n;
    mon_en = 0;
    rxq.delete();
    send_byte(8'h72, 1'b1);
    n = 0;
    while (uart_txd !== 1'b0 && n < 50) begin
      @(negedge clk_p);
      n++;
    end
    repeat (4) @(negedge clk_p);
    checks++; if (uart_txd !== 1'b0) begin fails++; $display("FAIL mid_txd_busy: got %b expected 0", uart_txd); end
    sys_reset = 1'b1;
    #1;
    checks++; if (uart_txd !== 1'b1) begin fails++; $display("FAIL mid_txd: got %b expected 1", uart_txd); end
    checks++; if (led !== 10'h000) begin fails++; $display("FAIL mid_led: got %h expected 000", led); end
    checks++; if (trig !== 1'b0) begin fails++; $display("FAIL mid_trig: got %b expected 0", trig); end
    repeat (3) @(negedge clk_p);
    sys_reset = 1'b0;
    saw_low = 0;
    repeat (400) begin
      @(negedge clk_p);
      if (uart_txd !== 1'b1) saw_low = 1;
    end
    checks++; if (saw_low) begin fails++; $display("FAIL mid_quiet: got txd activity expected idle"); end
    mon_en = 1;
    send_byte(8'h54, 1'b1);
    wait_reply(v, got);
    checks++; if (!got || v !== 9'h04B) begin fails++; $display("FAIL mid_t_reply: got %h (seen %0d) expected 04b", v, got); end
    checks++; if (trig !== 1'b1) begin fails++; $display("FAIL mid_t_trig: got %b expected 1", trig); end
  endtask

  initial begin
    test_reset();
    test_l_cmd();
    test_h_cmd();
    test_t_cmd();
    test_robust();
    test_back_to_back();
    test_reset_mid_reply();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
